// File: rtl/led_shift_pkg.sv
// Shared types and constants for the bouncing one-hot LED scanner.
package led_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_shift_tick.sv
// Step prescaler: counts enabled cycles and pulses tick_o on the last count of each period.
module led_shift_tick
  import led_shift_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Tick is combinational so the pattern steps on the same edge the count wraps.
  assign tick_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/led_shift.sv
// One-hot LED scanner: a single lit LED bounces across the bank, with start/pause control.
module led_shift
  import led_shift_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_led
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_step;
  logic             tick_en, tick_clr, tick;

  assign tick_en  = (state_q == RUN) && !i_stop;
  assign tick_clr = ((state_q == IDLE) && i_start) ||
                    ((state_q == PAUSE) && i_start && !i_stop);

  led_shift_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  assign led_step = (dir_q == DIR_LEFT) ? (led_q << 1) : (led_q >> 1);

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        led_d = '0;
        if (i_start) begin
          state_d = RUN;
          led_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          dir_d   = DIR_LEFT;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_d = PAUSE;
        end else if (tick) begin
          led_d = led_step;
          // Turn around on arrival at an end so the next step leaves it immediately.
          if ((dir_q == DIR_LEFT) && led_step[WIDTH-1]) begin
            dir_d = DIR_RIGHT;
          end else if ((dir_q == DIR_RIGHT) && led_step[0]) begin
            dir_d = DIR_LEFT;
          end
        end
      end
      PAUSE: begin
        if (i_start && !i_stop) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: tb/tb_led_shift.sv
// Bench for led_shift: two instances (TICK_DIV=4 and 1) driven together, checked against a bounce-position model.
module tb_led_shift;

  localparam int W = 8;
  localparam int P = 2 * (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] led4, led1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model per instance: mode 0=idle 1=run 2=pause, n = steps taken, ph = cycles since last step/resume.
  int mode [2];
  int n    [2];
  int ph   [2];

  logic [7:0] seq [15];

  always #50 clk = ~clk;

  led_shift #(.WIDTH(W), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .o_led(led4)
  );

  led_shift #(.WIDTH(W), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(start), .i_stop(stop), .o_led(led1)
  );

  function automatic int td_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Triangle wave: position after n steps starting from bit 0 heading left.
  function automatic int bounce_pos(input int steps);
    int m;
    m = steps % P;
    return (m <= W - 1) ? m : P - m;
  endfunction

  function automatic logic [W-1:0] exp_led(input int i);
    logic [W-1:0] one;
    one = 1;
    if (mode[i] == 0) return '0;
    return one << bounce_pos(n[i]);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mode[i] <= 0; n[i] <= 0; ph[i] <= 0;
      end else begin
        case (mode[i])
          0: if (start) begin mode[i] <= 1; n[i] <= 0; ph[i] <= 0; end
          1: begin
            if (stop) mode[i] <= 2;
            else if (ph[i] + 1 == td_of(i)) begin ph[i] <= 0; n[i] <= n[i] + 1; end
            else ph[i] <= ph[i] + 1;
          end
          default: if (start && !stop) begin mode[i] <= 1; ph[i] <= 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_div4", led4, exp_led(0));
      check("model_div1", led1, exp_led(1));
      check("onehot_div4", {7'd0, (mode[0] == 0) ? (led4 == '0) : $onehot(led4)}, 8'd1);
      check("onehot_div1", {7'd0, (mode[1] == 0) ? (led1 == '0) : $onehot(led1)}, 8'd1);
    end
  end

  task automatic drive(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    #2;
  endtask

  initial begin
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    mode = '{0, 0}; n = '{0, 0}; ph = '{0, 0};

    rst = 1'b1;
    drive(0, 0);
    chk_en = 1'b1;
    drive(0, 0);
    check("reset_led", led4, 8'h00);
    rst = 1'b0;
    drive(0, 0);
    drive(0, 0);
    check("idle_no_start", led4, 8'h00);
    drive(0, 1);
    check("idle_stop_only", led4, 8'h00);

    // Start held two cycles; the second cycle must not restart the pattern.
    drive(1, 0);
    check("start_first", led4, 8'h01);
    check("start_first_div1", led1, 8'h01);
    drive(1, 0);
    check("start_held", led4, 8'h01);
    check("div1_step1", led1, 8'h02);
    drive(0, 0);
    check("div1_step2", led1, 8'h04);
    drive(0, 0);
    drive(0, 0);
    check("first_step", led4, 8'h02);

    for (int j = 2; j < 15; j++) begin
      repeat (4) drive(0, 0);
      check("bounce_seq", led4, seq[j]);
    end

    repeat (12) drive(0, 0);
    check("pre_pause", led4, 8'h08);
    drive(0, 1);
    check("pause_edge", led4, 8'h08);
    repeat (20) begin
      drive(0, 0);
      check("pause_hold", led4, 8'h08);
    end
    drive(1, 0);
    check("resume_edge", led4, 8'h08);
    repeat (3) begin
      drive(0, 0);
      check("resume_wait", led4, 8'h08);
    end
    drive(0, 0);
    check("resume_step", led4, 8'h10);

    drive(1, 1);
    check("prio_run_stop", led4, 8'h10);
    repeat (5) begin
      drive(0, 0);
      check("prio_run_hold", led4, 8'h10);
    end

    // Reset while running with 0x10 lit.
    drive(1, 0);
    drive(0, 0);
    check("pre_reset", led4, 8'h10);
    rst = 1'b1;
    drive(0, 0);
    check("reset_midrun", led4, 8'h00);
    drive(0, 0);
    check("reset_midrun2", led4, 8'h00);
    rst = 1'b0;
    repeat (3) begin
      drive(0, 0);
      check("post_reset_idle", led4, 8'h00);
    end

    drive(1, 1);
    check("prio_idle_start", led4, 8'h01);
    check("prio_idle_start_div1", led1, 8'h01);

    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end
    rst = 1'b0;
    drive(0, 0);
    drive(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
